// File: rtl/pipeline_control_irq_return_pkg.sv
// Shared definitions for the interrupt-return sequencer: mode codes, ldst order codes,
// sequencer state encoding and the task-info entry address helper.
package pipeline_control_irq_return_pkg;

    localparam logic [1:0] CORE_MODE_USER  = 2'h3;
    localparam logic [1:0] LDST_ORDER_WORD = 2'h2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Entry base wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] entryBase(input logic [31:0] tisr,
                                              input logic [13:0] tid,
                                              input int unsigned shift);
        return tisr + ({18'h0, tid} << shift);
    endfunction

endpackage

// File: rtl/pipeline_control_word_ldst.sv
// Single-word load/store engine: issues one request when the port is free, reports
// issue and completion, and drives the port fields only while it owns the port.
module pipeline_control_word_ldst #(
    parameter logic [13:0] P_LDST_ASID = 14'h0
)(
    input  logic        active_i,
    input  logic        issue_i,
    input  logic        wait_i,
    input  logic        rw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        busy_i,
    input  logic        ack_i,
    output logic        issued_o,
    output logic        done_o,
    output logic        use_o,
    output logic        req_o,
    output logic [1:0]  order_o,
    output logic        rw_o,
    output logic [13:0] asid_o,
    output logic [1:0]  mmumod_o,
    output logic [31:0] pdt_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o
);
    import pipeline_control_irq_return_pkg::*;

    assign issued_o = active_i & issue_i & ~busy_i;
    assign done_o   = active_i & wait_i & ack_i;

    assign use_o    = active_i;
    assign req_o    = issued_o;
    assign order_o  = active_i ? LDST_ORDER_WORD : 2'h0;
    assign rw_o     = active_i & rw_i;
    assign asid_o   = active_i ? P_LDST_ASID : 14'h0;
    assign mmumod_o = 2'h0;
    assign pdt_o    = 32'h0;
    assign addr_o   = active_i ? addr_i : 32'h0;
    assign data_o   = (active_i && rw_i) ? data_i : 32'h0;

endmodule

// File: rtl/pipeline_control_irq_return.sv
// Interrupt-return sequencer: restores PC/PSR/SPR, swapping kernel and user SPR through
// the task-info area on user returns. IRQ_RETURN_KSPR_SAVE_EN enables the kernel SPR save.
module pipeline_control_irq_return #(
    parameter logic [13:0] P_LDST_ASID  = 14'h0,
    parameter int unsigned P_SLOT_SHIFT = 3
)(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic [31:0] iSYSREG_PPSR,
    input  logic [31:0] iSYSREG_PPCR,
    input  logic [31:0] iSYSREG_SPR,
    input  logic [31:0] iSYSREG_TISR,
    input  logic [31:0] iSYSREG_TIDR,
    input  logic        iRET_START,
    output logic        oBUSY,
    output logic        oFINISH,
    output logic [31:0] oFINISH_PC,
    output logic [31:0] oFINISH_PSR,
    output logic        oFINISH_SPR_VALID,
    output logic [31:0] oFINISH_SPR,
    output logic        oLDST_USE,
    output logic        oLDST_REQ,
    input  logic        iLDST_BUSY,
    output logic [1:0]  oLDST_ORDER,
    output logic        oLDST_RW,
    output logic [13:0] oLDST_ASID,
    output logic [1:0]  oLDST_MMUMOD,
    output logic [31:0] oLDST_PDT,
    output logic [31:0] oLDST_ADDR,
    output logic [31:0] oLDST_DATA,
    input  logic        iLDST_REQ,
    input  logic [31:0] iLDST_DATA
);
    import pipeline_control_irq_return_pkg::*;

`ifdef IRQ_RETURN_KSPR_SAVE_EN
    localparam state_e FirstUserState = ST_WR_REQ;
`else
    localparam state_e FirstUserState = ST_RD_REQ;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, psr_q, spr_q, base_q;
    logic        sprValid_q;

    logic        ldstActive, ldstIssue, ldstWait, ldstRw;
    logic [31:0] ldstAddr;
    logic        ldstIssued, ldstDone;

    logic        unusedTidrHi;
    assign unusedTidrHi = ^iSYSREG_TIDR[31:14];

    always_comb begin
        state_d    = state_q;
        ldstActive = 1'b0;
        ldstIssue  = 1'b0;
        ldstWait   = 1'b0;
        ldstRw     = 1'b0;
        ldstAddr   = base_q + 32'd4;
        case (state_q)
            ST_IDLE: begin
                if (iRET_START) begin
                    state_d = (iSYSREG_PPSR[6:5] == CORE_MODE_USER) ? FirstUserState : ST_DONE;
                end
            end
`ifdef IRQ_RETURN_KSPR_SAVE_EN
            ST_WR_REQ: begin
                ldstActive = 1'b1;
                ldstIssue  = 1'b1;
                ldstRw     = 1'b1;
                ldstAddr   = base_q;
                if (ldstIssued) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                ldstActive = 1'b1;
                ldstWait   = 1'b1;
                ldstRw     = 1'b1;
                ldstAddr   = base_q;
                if (ldstDone) state_d = ST_RD_REQ;
            end
`endif
            ST_RD_REQ: begin
                ldstActive = 1'b1;
                ldstIssue  = 1'b1;
                if (ldstIssued) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                ldstActive = 1'b1;
                ldstWait   = 1'b1;
                if (ldstDone) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // spr_q holds the kernel SPR for the save, then is overwritten by the restored user SPR.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q    <= ST_IDLE;
            pc_q       <= 32'h0;
            psr_q      <= 32'h0;
            spr_q      <= 32'h0;
            base_q     <= 32'h0;
            sprValid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && iRET_START) begin
                pc_q       <= iSYSREG_PPCR;
                psr_q      <= iSYSREG_PPSR;
                spr_q      <= iSYSREG_SPR;
                base_q     <= entryBase(iSYSREG_TISR, iSYSREG_TIDR[13:0], P_SLOT_SHIFT);
                sprValid_q <= 1'b0;
            end else if (state_q == ST_RD_WAIT && ldstDone) begin
                spr_q      <= iLDST_DATA;
                sprValid_q <= 1'b1;
            end
        end
    end

    pipeline_control_word_ldst #(
        .P_LDST_ASID(P_LDST_ASID)
    ) u_word_ldst (
        .active_i (ldstActive),
        .issue_i  (ldstIssue),
        .wait_i   (ldstWait),
        .rw_i     (ldstRw),
        .addr_i   (ldstAddr),
        .data_i   (spr_q),
        .busy_i   (iLDST_BUSY),
        .ack_i    (iLDST_REQ),
        .issued_o (ldstIssued),
        .done_o   (ldstDone),
        .use_o    (oLDST_USE),
        .req_o    (oLDST_REQ),
        .order_o  (oLDST_ORDER),
        .rw_o     (oLDST_RW),
        .asid_o   (oLDST_ASID),
        .mmumod_o (oLDST_MMUMOD),
        .pdt_o    (oLDST_PDT),
        .addr_o   (oLDST_ADDR),
        .data_o   (oLDST_DATA)
    );

    assign oBUSY             = (state_q != ST_IDLE);
    assign oFINISH           = (state_q == ST_DONE);
    assign oFINISH_PC        = oFINISH ? pc_q : 32'h0;
    assign oFINISH_PSR       = oFINISH ? psr_q : 32'h0;
    assign oFINISH_SPR_VALID = oFINISH & sprValid_q;
    assign oFINISH_SPR       = oFINISH ? spr_q : 32'h0;

endmodule

// File: tb/tb_pipeline_control_irq_return.sv
// Self-checking bench for the interrupt-return sequencer: directed scenarios plus
// randomized returns against a rule-level model of accesses, latency and results.
module tb_pipeline_control_irq_return;
    import pipeline_control_irq_return_pkg::*;

`ifdef IRQ_RETURN_KSPR_SAVE_EN
    localparam bit WritePhase = 1'b1;
`else
    localparam bit WritePhase = 1'b0;
`endif

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC;
    logic [31:0] iSYSREG_PPSR, iSYSREG_PPCR, iSYSREG_SPR, iSYSREG_TISR, iSYSREG_TIDR;
    logic        iRET_START;
    logic        oBUSY, oFINISH, oFINISH_SPR_VALID;
    logic [31:0] oFINISH_PC, oFINISH_PSR, oFINISH_SPR;
    logic        oLDST_USE, oLDST_REQ, oLDST_RW;
    logic        iLDST_BUSY;
    logic [1:0]  oLDST_ORDER, oLDST_MMUMOD;
    logic [13:0] oLDST_ASID;
    logic [31:0] oLDST_PDT, oLDST_ADDR, oLDST_DATA;
    logic        iLDST_REQ = 1'b0;
    logic [31:0] iLDST_DATA = 32'h0;

    always #5 iCLOCK = ~iCLOCK;

    pipeline_control_irq_return dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iSYSREG_PPSR(iSYSREG_PPSR), .iSYSREG_PPCR(iSYSREG_PPCR), .iSYSREG_SPR(iSYSREG_SPR),
        .iSYSREG_TISR(iSYSREG_TISR), .iSYSREG_TIDR(iSYSREG_TIDR), .iRET_START(iRET_START),
        .oBUSY(oBUSY), .oFINISH(oFINISH), .oFINISH_PC(oFINISH_PC), .oFINISH_PSR(oFINISH_PSR),
        .oFINISH_SPR_VALID(oFINISH_SPR_VALID), .oFINISH_SPR(oFINISH_SPR),
        .oLDST_USE(oLDST_USE), .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY),
        .oLDST_ORDER(oLDST_ORDER), .oLDST_RW(oLDST_RW), .oLDST_ASID(oLDST_ASID),
        .oLDST_MMUMOD(oLDST_MMUMOD), .oLDST_PDT(oLDST_PDT), .oLDST_ADDR(oLDST_ADDR),
        .oLDST_DATA(oLDST_DATA), .iLDST_REQ(iLDST_REQ), .iLDST_DATA(iLDST_DATA)
    );

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          reqSeen = 0;
    int          acked = 0;
    int          finCount = 0;
    int          finCycle = 0;
    int          reqWhileBusy = 0;
    int          fieldLeak = 0;
    int          protoErr = 0;
    bit          monOn = 1'b0;
    bit          ackEnable = 1'b1;
    bit          forceAck = 1'b0;
    logic [31:0] ackData = 32'h0;
    logic [31:0] finPc, finPsr, finSpr;
    logic        finSprValid;
    req_t        reqLog[$];

    // Observes the port at mid-cycle: logs requests and finishes, checks idle-port hygiene.
    always @(negedge iCLOCK) begin
        req_t rec;
        cycle++;
        if (oLDST_REQ === 1'b1) begin
            rec.rw   = oLDST_RW;
            rec.addr = oLDST_ADDR;
            rec.data = oLDST_DATA;
            reqLog.push_back(rec);
            reqSeen++;
            if (iLDST_BUSY) reqWhileBusy++;
        end
        if (oFINISH === 1'b1) begin
            finCount++;
            finCycle    = cycle;
            finPc       = oFINISH_PC;
            finPsr      = oFINISH_PSR;
            finSpr      = oFINISH_SPR;
            finSprValid = oFINISH_SPR_VALID;
        end
        if (monOn) begin
            if (oLDST_USE !== 1'b1) begin
                if ({oLDST_REQ, oLDST_ORDER, oLDST_RW, oLDST_ASID, oLDST_MMUMOD,
                     oLDST_PDT, oLDST_ADDR, oLDST_DATA} !== '0) fieldLeak++;
            end else if (oLDST_ORDER !== 2'h2 || oLDST_ASID !== 14'h0 ||
                         oLDST_MMUMOD !== 2'h0 || oLDST_PDT !== 32'h0) begin
                protoErr++;
            end
        end
    end

    // Memory responder: acknowledges each issued request in the following cycle.
    always @(posedge iCLOCK) begin
        #2;
        if (reqSeen > acked) begin
            acked++;
            iLDST_REQ = ackEnable | forceAck;
        end else begin
            iLDST_REQ = forceAck;
        end
        iLDST_DATA = ackData;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        logic [215:0] v;
        v = {oBUSY, oFINISH, oFINISH_PC, oFINISH_PSR, oFINISH_SPR_VALID, oFINISH_SPR,
             oLDST_USE, oLDST_REQ, oLDST_ORDER, oLDST_RW, oLDST_ASID, oLDST_MMUMOD,
             oLDST_PDT, oLDST_ADDR, oLDST_DATA};
        total++;
        assert (v === '0) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=0", tag, v);
        end
    endtask

    // Runs one return and checks it against the rule-level expectation.
    task automatic applyStimulus(input string tag, input logic [31:0] ppsr, input logic [31:0] ppcr,
                                 input logic [31:0] spr, input logic [31:0] tisr,
                                 input logic [31:0] tidr, input logic [31:0] rdata,
                                 input int busyN, input int extraStartAt);
        bit          isUser;
        logic [31:0] base;
        int          expLat, wOff, r0, f0, s0, busyLow, nExp;
        bit          done;
        req_t        expReq[$];
        req_t        e;

        isUser = (ppsr[6:5] == CORE_MODE_USER);
        base   = tisr + (tidr % 32'h4000) * 32'd8;
        wOff   = WritePhase ? 2 : 0;
        expLat = isUser ? ((WritePhase ? 5 : 3) + busyN) : 1;
        if (isUser && WritePhase) begin
            e.rw = 1'b1; e.addr = base; e.data = spr;
            expReq.push_back(e);
        end
        if (isUser) begin
            e.rw = 1'b0; e.addr = base + 32'd4; e.data = 32'h0;
            expReq.push_back(e);
        end
        nExp = expReq.size();
        r0 = reqLog.size();
        f0 = finCount;

        @(posedge iCLOCK); #1;
        iSYSREG_PPSR = ppsr; iSYSREG_PPCR = ppcr; iSYSREG_SPR = spr;
        iSYSREG_TISR = tisr; iSYSREG_TIDR = tidr;
        ackData = rdata; iLDST_BUSY = 1'b0; iRET_START = 1'b1;
        @(negedge iCLOCK); #1;
        s0 = cycle;
        busyLow = 0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge iCLOCK); #1;
            iRET_START = (k == extraStartAt);
            iLDST_BUSY = isUser && (k > wOff) && (k <= wOff + busyN);
            @(negedge iCLOCK); #1;
            if (oBUSY !== 1'b1) busyLow++;
            if (finCount != f0) done = 1'b1;
        end
        @(posedge iCLOCK); #1;
        iRET_START = 1'b0; iLDST_BUSY = 1'b0;
        @(negedge iCLOCK); #1;

        checkOutput({tag, "_finish_count"}, 64'(finCount - f0), 64'd1);
        checkOutput({tag, "_latency"}, 64'(finCycle - s0), 64'(expLat));
        checkOutput({tag, "_pc"}, 64'(finPc), 64'(ppcr));
        checkOutput({tag, "_psr"}, 64'(finPsr), 64'(ppsr));
        checkOutput({tag, "_spr_valid"}, 64'(finSprValid), 64'(isUser));
        checkOutput({tag, "_spr"}, 64'(finSpr), 64'(isUser ? rdata : spr));
        checkOutput({tag, "_busy_held"}, 64'(busyLow), 64'd0);
        checkOutput({tag, "_idle_after"}, 64'(oBUSY), 64'd0);
        checkOutput({tag, "_req_count"}, 64'(reqLog.size() - r0), 64'(nExp));
        for (int i = 0; i < nExp && (r0 + i) < reqLog.size(); i++) begin
            checkOutput($sformatf("%s_req%0d_rw", tag, i), 64'(reqLog[r0+i].rw), 64'(expReq[i].rw));
            checkOutput($sformatf("%s_req%0d_addr", tag, i), 64'(reqLog[r0+i].addr), 64'(expReq[i].addr));
            if (expReq[i].rw)
                checkOutput($sformatf("%s_req%0d_data", tag, i), 64'(reqLog[r0+i].data), 64'(expReq[i].data));
        end
    endtask

    initial begin
        logic [31:0] rp, rc, rs, rt, ri, rd;
        int          f0;

        iRESET_SYNC = 1'b1; iRET_START = 1'b1; iLDST_BUSY = 1'b0;
        iSYSREG_PPSR = 32'h60; iSYSREG_PPCR = 32'h1234; iSYSREG_SPR = 32'h1;
        iSYSREG_TISR = 32'h8000; iSYSREG_TIDR = 32'h2;
        repeat (3) @(posedge iCLOCK);
        #1 iRET_START = 1'b0;
        @(negedge iCLOCK); #1;
        checkAllZero("reset_outputs");
        monOn = 1'b1;
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0;

        applyStimulus("kernel", 32'h0000_0000, 32'h0000_1000, 32'h1234_5678,
                      32'h8000, 32'h2, 32'hDEAD_BEEF, 0, 0);
        applyStimulus("user", 32'h0000_0060, 32'h0000_2000, 32'hAAAA_0000,
                      32'h8000, 32'h2, 32'h5555_0000, 0, 0);
        applyStimulus("busy3", 32'h0000_0060, 32'h0000_3000, 32'h0BAD_0001,
                      32'h1_0000, 32'h7, 32'h0600_D001, 3, 0);
        applyStimulus("restart_ignored", 32'h0000_0060, 32'h0000_4000, 32'h1111_2222,
                      32'h2_0000, 32'h5, 32'h3333_4444, 0, (WritePhase ? 2 : 0) + 2);
        applyStimulus("wrap", 32'hF000_00E0, 32'hFFFF_FFFC, 32'h7777_7777,
                      32'hFFFF_FFF8, 32'hFFFF_C000, 32'h8888_8888, 1, 0);

        // Reset while waiting for an access ack, followed by a stray late ack.
        f0 = finCount;
        @(posedge iCLOCK); #1;
        iSYSREG_PPSR = 32'h60; iSYSREG_TISR = 32'h8000; iSYSREG_TIDR = 32'h2;
        iRET_START = 1'b1;
        @(posedge iCLOCK); #1;
        iRET_START = 1'b0;
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b1; ackEnable = 1'b0;
        @(negedge iCLOCK); #1;
        checkOutput("midreset_in_access", 64'(oLDST_USE), 64'd1);
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0; forceAck = 1'b1;
        @(negedge iCLOCK); #1;
        checkAllZero("midreset_outputs");
        @(posedge iCLOCK); #1;
        forceAck = 1'b0; ackEnable = 1'b1;
        repeat (3) @(posedge iCLOCK);
        @(negedge iCLOCK); #1;
        checkOutput("midreset_no_finish", 64'(finCount - f0), 64'd0);
        checkOutput("midreset_idle", 64'(oBUSY), 64'd0);

        for (int i = 0; i < 10; i++) begin
            rp = $urandom;
            if ($urandom_range(0, 1) == 1) rp[6:5] = CORE_MODE_USER;
            rc = $urandom; rs = $urandom; rt = $urandom; ri = $urandom; rd = $urandom;
            applyStimulus($sformatf("rnd%0d", i), rp, rc, rs, rt, ri, rd,
                          int'($urandom_range(0, 3)), 0);
        end

        checkOutput("req_while_busy", 64'(reqWhileBusy), 64'd0);
        checkOutput("idle_port_fields", 64'(fieldLeak), 64'd0);
        checkOutput("port_constants", 64'(protoErr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
